lfsr_search_ctrl: RTL and testbench
===================================

// Module: lfsr_search_ctrl
// PURPOSE
//   Upstream sequencer for the Data_Compare stage of the LFSR associative memory.
//   On Start it latches a search key and walks all 2^ADDR_W memory words in LFSR order.
//   It drives the compare stage with Key and a one-cycle-aligned enable.
//   It stops at the first hit and reports Found/Match_Addr with a one-cycle Done pulse.
// PARAMETERS
//   DATA_W  8        key / memory word width (matches Data_Compare, 8)
//   ADDR_W  4        memory address width; the memory has 2^ADDR_W words
//   TAPS    4'b1001  Fibonacci feedback mask: fb = ^(lfsr & TAPS), next = {lfsr[ADDR_W-2:0], fb}
//   SEED    4'b0001  first address visited; must be non-zero (elaboration-time check)
// PORTS
//   Clk            in   1       single clock; all state on rising edge
//   Rst_n          in   1       asynchronous, active-low reset
//   Start          in   1       request a search; sampled only in IDLE
//   Key            in   DATA_W  search key; captured on the Start edge
//   Mem_Addr       out  ADDR_W  read address to the synchronous memory
//   Mem_Rd_En      out  1       read strobe; the memory returns Mem_Data one cycle later
//   Cmp_Temp       out  DATA_W  latched key -> Data_Compare.Temp
//   Cmp_Enable     out  1       Mem_Data valid this cycle -> Data_Compare.enable
//   Compare_Found  in   1       combinational hit from Data_Compare
//   Busy           out  1       high in SEARCH and DRAIN
//   Done           out  1       one-cycle pulse at search end
//   Found          out  1       result flag; held until the next accepted Start
//   Match_Addr     out  ADDR_W  hit address; held until the next accepted Start, 0 if no hit
// BEHAVIOUR
//   - Reset: state IDLE, lfsr=SEED, count=0, key=0, all outputs 0.
//   - FSM states:
//     IDLE:   Start=1 -> latch Key, lfsr<=SEED, count<=0, clear Found/Match_Addr -> SEARCH.
//     SEARCH: Mem_Rd_En=1; Mem_Addr = (count==2^ADDR_W-1) ? 0 : lfsr.
//             Each edge: lfsr advances, count++.
//             After the read at count==2^ADDR_W-1 -> DRAIN.
//             A hit sampled in SEARCH -> DONE; the read in flight is discarded.
//     DRAIN:  Mem_Rd_En=0; wait for the compare of the final read. Hit or not -> DONE.
//     DONE:   Done=1 for exactly one cycle -> IDLE.
//   - Address order: the 2^ADDR_W-1 non-zero LFSR states from SEED, then address 0 last.
//     Every word is read exactly once.
//   - Pipeline: rd_addr_q <= Mem_Addr and Cmp_Enable <= Mem_Rd_En on each edge.
//   - Hit condition: Cmp_Enable & Compare_Found at an edge.
//     On a hit: Found<=1, Match_Addr<=rd_addr_q.
//   - Compare_Found is ignored whenever Cmp_Enable=0.
//   - Cmp_Temp = latched key, stable from the Start edge until the next accepted Start.
//   - Latency: Start sampled at edge k; the n-th read (n = 0..2^ADDR_W-1) is compared
//     after edge k+n+1. On a hit at n, Done is high after edge k+n+2.
//     Worst case (hit at address 0, or no hit): Done after edge k+2^ADDR_W+1.
//   - Boundaries:
//     Start while Busy or in DONE: ignored, with no effect on key or results.
//     Start high continuously: a new search starts on the first IDLE cycle.
//     Duplicate keys in memory: the first match in LFSR order wins.
//     Rst_n low mid-search: immediate return to reset values, no Done pulse.
//   - count is ADDR_W+1 bits wide and never wraps within one search.
// STRUCTURE
//   - Package lfsr_search_pkg: state enum {IDLE,SEARCH,DRAIN,DONE}, default TAPS/SEED
//     constants.
//   - Sub-module lfsr_addr_gen (params ADDR_W, TAPS, SEED; ports Clk, Rst_n, load, step,
//     lfsr).
//   - FSM, pipeline registers and result registers stay in this module.
// TESTING  (defaults; LFSR order 0001,0011,0111,1111,1110,...,1000, then 0000)
//   1. Key=8'hA5 at addr 4'b0001, Start at edge k
//      -> Done after edge k+2, Found=1, Match_Addr=4'b0001.
//   2. Key at addr 4'b0111 only
//      -> Mem_Addr sequence 0001,0011,0111; Done after edge k+4, Match_Addr=4'b0111.
//   3. Key absent
//      -> 16 reads, all 16 addresses once; Done after edge k+17, Found=0, Match_Addr=0.
//   4. Key at addr 0 only
//      -> address 0 is the 16th read; Done after edge k+17, Found=1, Match_Addr=0.
//   5. Key at 4'b0011 and 4'b1000 -> Match_Addr=4'b0011.
//      Second Start pulsed mid-search -> no effect.
//   6. Rst_n low at edge k+5 of a search -> all outputs 0 at once, no Done.
//      Start after release -> normal search.

Source files
------------

// File: rtl/lfsr_search_pkg.sv
// lfsr_search_pkg
//   Shared types and default constants for the LFSR associative-memory search
//   sequencer (lfsr_search_ctrl) and its address generator (lfsr_addr_gen).
//   Contents:
//     state_e       sequencer states IDLE / SEARCH / DRAIN / DONE
//     DEFAULT_TAPS  Fibonacci feedback mask for a 4-bit maximal-length LFSR
//     DEFAULT_SEED  first non-zero address visited by a search

package lfsr_search_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DRAIN  = 2'd2,
        DONE   = 2'd3
    } state_e;

    // x^4 + x^3 + 1 style mask; walks all 15 non-zero 4-bit states.
    localparam logic [3:0] DEFAULT_TAPS = 4'b1001;
    localparam logic [3:0] DEFAULT_SEED = 4'b0001;

endpackage : lfsr_search_pkg

// File: rtl/lfsr_search_ctrl_addr_gen.sv
// lfsr_addr_gen
//   Fibonacci LFSR used as the memory address walker. Feedback is the XOR of
//   the bits selected by TAPS, shifted in at the LSB.
//   Ports:
//     Clk_i    in   1       clock, rising edge
//     Rst_n_i  in   1       asynchronous active-low reset (lfsr -> SEED)
//     load_i   in   1       reload SEED (has priority over step_i)
//     step_i   in   1       advance one LFSR state
//     lfsr_o   out  ADDR_W  current LFSR state

module lfsr_addr_gen
    import lfsr_search_pkg::*;
#(
    parameter int                ADDR_W = 4,
    parameter logic [ADDR_W-1:0] TAPS   = ADDR_W'(DEFAULT_TAPS),
    parameter logic [ADDR_W-1:0] SEED   = ADDR_W'(DEFAULT_SEED)
) (
    input  logic              Clk_i,
    input  logic              Rst_n_i,
    input  logic              load_i,
    input  logic              step_i,
    output logic [ADDR_W-1:0] lfsr_o
);

    // An all-zero seed is the LFSR lock-up state and would never advance.
    generate
        if (SEED == '0) begin : g_bad_seed
            $error("lfsr_addr_gen: SEED must be non-zero");
        end
    endgenerate

    logic [ADDR_W-1:0] lfsr_q;
    logic [ADDR_W-1:0] lfsr_d;
    logic              fb;

    always_comb begin
        fb     = ^(lfsr_q & TAPS);
        lfsr_d = lfsr_q;
        if (load_i) begin
            lfsr_d = SEED;
        end else if (step_i) begin
            lfsr_d = {lfsr_q[ADDR_W-2:0], fb};
        end
    end

    always_ff @(posedge Clk_i or negedge Rst_n_i) begin
        if (!Rst_n_i) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr_o = lfsr_q;

endmodule : lfsr_addr_gen

// File: rtl/lfsr_search_ctrl.sv
// lfsr_search_ctrl
//   Upstream sequencer for the Data_Compare stage of the LFSR associative
//   memory. On Start it latches a key and reads every memory word once in LFSR
//   order (non-zero states from SEED, then address 0). The compare stage sees
//   the latched key plus an enable aligned with the synchronous read data. The
//   search stops at the first hit and reports Found/Match_Addr with a
//   one-cycle Done pulse.
//   Ports:
//     Clk_i            in   1       clock, rising edge
//     Rst_n_i          in   1       asynchronous active-low reset
//     Start_i          in   1       search request, sampled only in IDLE
//     Key_i            in   DATA_W  search key, captured on the Start edge
//     Mem_Addr_o       out  ADDR_W  read address to the synchronous memory
//     Mem_Rd_En_o      out  1       read strobe (data returns one cycle later)
//     Cmp_Temp_o       out  DATA_W  latched key to Data_Compare.Temp
//     Cmp_Enable_o     out  1       Mem_Data valid this cycle
//     Compare_Found_i  in   1       combinational hit from Data_Compare
//     Busy_o           out  1       high in SEARCH and DRAIN
//     Done_o           out  1       one-cycle pulse at search end
//     Found_o          out  1       result flag, held until next accepted Start
//     Match_Addr_o     out  ADDR_W  hit address, 0 when nothing matched

module lfsr_search_ctrl
    import lfsr_search_pkg::*;
#(
    parameter int                DATA_W = 8,
    parameter int                ADDR_W = 4,
    parameter logic [ADDR_W-1:0] TAPS   = ADDR_W'(DEFAULT_TAPS),
    parameter logic [ADDR_W-1:0] SEED   = ADDR_W'(DEFAULT_SEED)
) (
    input  logic              Clk_i,
    input  logic              Rst_n_i,
    input  logic              Start_i,
    input  logic [DATA_W-1:0] Key_i,
    output logic [ADDR_W-1:0] Mem_Addr_o,
    output logic              Mem_Rd_En_o,
    output logic [DATA_W-1:0] Cmp_Temp_o,
    output logic              Cmp_Enable_o,
    input  logic              Compare_Found_i,
    output logic              Busy_o,
    output logic              Done_o,
    output logic              Found_o,
    output logic [ADDR_W-1:0] Match_Addr_o
);

    // Index of the final read; the count is one bit wider so it never wraps.
    localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W+1)'((1 << ADDR_W) - 1);

    state_e            state_q, state_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [DATA_W-1:0] key_q, key_d;
    logic              found_q, found_d;
    logic [ADDR_W-1:0] match_addr_q, match_addr_d;
    logic [ADDR_W-1:0] rd_addr_q;
    logic              cmp_en_q;

    logic [ADDR_W-1:0] lfsr;
    logic              start_accept;
    logic              last_read;
    logic              hit;

    assign start_accept = (state_q == IDLE) && Start_i;
    assign last_read    = (count_q == LAST_CNT);

    // A compare is only meaningful while a search owns the pipeline; the
    // read still in flight when DONE is entered is deliberately dropped.
    assign hit = cmp_en_q && Compare_Found_i &&
                 ((state_q == SEARCH) || (state_q == DRAIN));

    lfsr_addr_gen #(
        .ADDR_W (ADDR_W),
        .TAPS   (TAPS),
        .SEED   (SEED)
    ) u_addr_gen (
        .Clk_i   (Clk_i),
        .Rst_n_i (Rst_n_i),
        .load_i  (start_accept),
        .step_i  (state_q == SEARCH),
        .lfsr_o  (lfsr)
    );

    // State register.
    always_ff @(posedge Clk_i or negedge Rst_n_i) begin
        if (!Rst_n_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a hit takes priority over finishing the walk.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (Start_i) begin
                    state_d = SEARCH;
                end
            end
            SEARCH: begin
                if (hit) begin
                    state_d = DONE;
                end else if (last_read) begin
                    state_d = DRAIN;
                end
            end
            DRAIN:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs. Address 0 is the LFSR lock-up state, so it is substituted
    // for the final read instead of being produced by the LFSR.
    always_comb begin
        Mem_Rd_En_o = 1'b0;
        Mem_Addr_o  = '0;
        Busy_o      = 1'b0;
        Done_o      = 1'b0;
        case (state_q)
            SEARCH: begin
                Mem_Rd_En_o = 1'b1;
                Mem_Addr_o  = last_read ? '0 : lfsr;
                Busy_o      = 1'b1;
            end
            DRAIN: begin
                Busy_o = 1'b1;
            end
            DONE: begin
                Done_o = 1'b1;
            end
            default: ;
        endcase
    end

    // Key, read counter and result registers.
    always_comb begin
        count_d      = count_q;
        key_d        = key_q;
        found_d      = found_q;
        match_addr_d = match_addr_q;
        if (start_accept) begin
            count_d      = '0;
            key_d        = Key_i;
            found_d      = 1'b0;
            match_addr_d = '0;
        end else begin
            if (state_q == SEARCH) begin
                count_d = count_q + 1'b1;
            end
            if (hit) begin
                found_d      = 1'b1;
                match_addr_d = rd_addr_q;
            end
        end
    end

    always_ff @(posedge Clk_i or negedge Rst_n_i) begin
        if (!Rst_n_i) begin
            count_q      <= '0;
            key_q        <= '0;
            found_q      <= 1'b0;
            match_addr_q <= '0;
        end else begin
            count_q      <= count_d;
            key_q        <= key_d;
            found_q      <= found_d;
            match_addr_q <= match_addr_d;
        end
    end

    // Pipeline stage matching the one-cycle memory read latency: the address
    // and enable travel alongside the data the memory is returning.
    always_ff @(posedge Clk_i or negedge Rst_n_i) begin
        if (!Rst_n_i) begin
            rd_addr_q <= '0;
            cmp_en_q  <= 1'b0;
        end else begin
            rd_addr_q <= Mem_Addr_o;
            cmp_en_q  <= Mem_Rd_En_o;
        end
    end

    assign Cmp_Temp_o   = key_q;
    assign Cmp_Enable_o = cmp_en_q;
    assign Found_o      = found_q;
    assign Match_Addr_o = match_addr_q;

endmodule : lfsr_search_ctrl

// File: tb/tb_lfsr_search_ctrl.sv
// tb_lfsr_search_ctrl
//   Scoreboard bench for lfsr_search_ctrl. A behavioural synchronous memory and
//   an ungated Data_Compare model surround the DUT. Stimulus pushes the expected
//   read addresses and search results into queues; a monitor on the falling
//   edge pops and compares them whenever the DUT issues a read or pulses Done.

module tb_lfsr_search_ctrl;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;

    typedef struct {
        logic       found;
        logic [3:0] addr;
        int         latency;
    } result_t;

    logic              clk     = 1'b0;
    logic              rst_n   = 1'b0;
    logic              start   = 1'b0;
    logic [DATA_W-1:0] key     = '0;
    logic [ADDR_W-1:0] memAddr;
    logic              memRdEn;
    logic [DATA_W-1:0] cmpTemp;
    logic              cmpEnable;
    logic              compareFound;
    logic              busy;
    logic              doneO;
    logic              found;
    logic [ADDR_W-1:0] matchAddr;

    logic [DATA_W-1:0] mem [16];
    logic [DATA_W-1:0] memData = '0;

    // Hand-derived visiting order for TAPS=1001, SEED=0001, address 0 last.
    logic [3:0] lfsrOrder [16] = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hD, 4'hA, 4'h5,
                                   4'hB, 4'h6, 4'hC, 4'h9, 4'h2, 4'h4, 4'h8, 4'h0};

    result_t    resQ[$];
    logic [3:0] addrQ[$];

    int   checks    = 0;
    int   errors    = 0;
    int   edgeCnt   = 0;
    int   startEdge = 0;
    int   doneCount = 0;
    int   expDone   = 0;
    logic prevDone  = 1'b0;

    lfsr_search_ctrl #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .Clk_i           (clk),
        .Rst_n_i         (rst_n),
        .Start_i         (start),
        .Key_i           (key),
        .Mem_Addr_o      (memAddr),
        .Mem_Rd_En_o     (memRdEn),
        .Cmp_Temp_o      (cmpTemp),
        .Cmp_Enable_o    (cmpEnable),
        .Compare_Found_i (compareFound),
        .Busy_o          (busy),
        .Done_o          (doneO),
        .Found_o         (found),
        .Match_Addr_o    (matchAddr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edgeCnt <= edgeCnt + 1;

    // Synchronous memory and a compare that is deliberately not gated by the
    // enable, so stale matches outside a search must be ignored by the DUT.
    always @(posedge clk) if (memRdEn) memData <= mem[memAddr];
    assign compareFound = (memData == cmpTemp);

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: read-address and result scoreboards.
    always @(negedge clk) begin
        if (rst_n) begin
            if (memRdEn) begin
                checkOutput("read expected", 32'(addrQ.size() > 0), 32'd1);
                if (addrQ.size() > 0) begin
                    checkOutput("read address", 32'(memAddr), 32'(addrQ.pop_front()));
                end
            end
            if (doneO) begin
                checkOutput("done expected", 32'(resQ.size() > 0), 32'd1);
                if (resQ.size() > 0) begin
                    result_t r;
                    r = resQ.pop_front();
                    checkOutput("result found", 32'(found), 32'(r.found));
                    checkOutput("result match addr", 32'(matchAddr), 32'(r.addr));
                    checkOutput("done latency", 32'(edgeCnt - startEdge), 32'(r.latency));
                end
                doneCount++;
            end
            if (prevDone) begin
                checkOutput("done single cycle", 32'(doneO), 32'd0);
            end
            prevDone = doneO;
        end else begin
            prevDone = 1'b0;
        end
    end

    task automatic setMem();
        for (int i = 0; i < 16; i++) mem[i] = 8'h10 + 8'(i);
    endtask

    task automatic pushAddrs(input int n);
        for (int i = 0; i < n; i++) addrQ.push_back(lfsrOrder[i]);
    endtask

    task automatic pushResult(input logic f, input logic [3:0] a, input int lat);
        resQ.push_back('{found: f, addr: a, latency: lat});
        expDone++;
    endtask

    // Single-cycle Start pulse; startEdge marks the edge that samples it.
    task automatic applyStimulus(input logic [DATA_W-1:0] k);
        @(negedge clk);
        start = 1'b1;
        key   = k;
        @(posedge clk);
        #1;
        startEdge = edgeCnt;
        start     = 1'b0;
    endtask

    task automatic waitDone(input int limit);
        int n = 0;
        while (doneCount < expDone && n < limit) begin
            @(posedge clk);
            n++;
        end
        @(negedge clk);
        checkOutput("done within budget", 32'(doneCount >= expDone), 32'd1);
        if (doneCount < expDone) begin
            resQ.delete();
            addrQ.delete();
            expDone = doneCount;
        end
    endtask

    task automatic checkHeld(input logic f, input logic [3:0] a, input logic [DATA_W-1:0] k);
        repeat (3) @(negedge clk);
        checkOutput("held found", 32'(found), 32'(f));
        checkOutput("held match addr", 32'(matchAddr), 32'(a));
        checkOutput("held key", 32'(cmpTemp), 32'(k));
        checkOutput("idle busy", 32'(busy), 32'd0);
    endtask

    initial begin
        setMem();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset done", 32'(doneO), 32'd0);
        checkOutput("reset found/match", 32'({found, matchAddr}), 32'd0);
        checkOutput("reset mem port", 32'({memRdEn, memAddr}), 32'd0);
        checkOutput("reset compare port", 32'({cmpEnable, cmpTemp}), 32'd0);

        $display("[TB] hit at first address");
        setMem(); mem[1] = 8'hA5;
        pushAddrs(2); pushResult(1'b1, 4'h1, 2);
        applyStimulus(8'hA5);
        waitDone(40);
        checkHeld(1'b1, 4'h1, 8'hA5);

        $display("[TB] hit at third address");
        setMem(); mem[7] = 8'h5A;
        pushAddrs(4); pushResult(1'b1, 4'h7, 4);
        applyStimulus(8'h5A);
        checkOutput("start clears result", 32'({found, matchAddr}), 32'd0);
        checkOutput("busy after start", 32'(busy), 32'd1);
        checkOutput("key latched", 32'(cmpTemp), 32'h5A);
        waitDone(40);
        checkHeld(1'b1, 4'h7, 8'h5A);

        $display("[TB] hit at address 0 only");
        setMem(); mem[0] = 8'hC3;
        pushAddrs(16); pushResult(1'b1, 4'h0, 17);
        applyStimulus(8'hC3);
        waitDone(40);
        checkHeld(1'b1, 4'h0, 8'hC3);

        $display("[TB] key absent");
        setMem();
        pushAddrs(16); pushResult(1'b0, 4'h0, 17);
        applyStimulus(8'h77);
        checkOutput("start clears found", 32'(found), 32'd0);
        waitDone(40);
        checkHeld(1'b0, 4'h0, 8'h77);

        $display("[TB] duplicate keys, Start while busy and in DONE");
        setMem(); mem[3] = 8'hE1; mem[8] = 8'hE1;
        pushAddrs(3); pushResult(1'b1, 4'h3, 3);
        applyStimulus(8'hE1);
        @(negedge clk);
        start = 1'b1; key = 8'h12;
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("busy start ignored key", 32'(cmpTemp), 32'hE1);
        for (int i = 0; i < 10 && !doneO; i++) @(negedge clk);
        start = 1'b1; key = 8'h12;
        @(posedge clk);
        #1;
        start = 1'b0;
        waitDone(40);
        checkOutput("done start ignored", 32'(busy), 32'd0);
        checkHeld(1'b1, 4'h3, 8'hE1);

        $display("[TB] Start held high across two searches");
        setMem(); mem[1] = 8'h66;
        pushAddrs(2); pushResult(1'b1, 4'h1, 2);
        pushAddrs(2); pushResult(1'b1, 4'h1, 6);
        @(negedge clk);
        start = 1'b1; key = 8'h66;
        @(posedge clk);
        #1;
        startEdge = edgeCnt;
        repeat (4) @(posedge clk);
        #1;
        start = 1'b0;
        waitDone(40);
        checkHeld(1'b1, 4'h1, 8'h66);

        $display("[TB] reset mid-search");
        setMem(); mem[8] = 8'h9F;
        pushAddrs(5);
        applyStimulus(8'h9F);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("async reset busy/done", 32'({busy, doneO}), 32'd0);
        checkOutput("async reset mem port", 32'({memRdEn, memAddr}), 32'd0);
        checkOutput("async reset compare port", 32'({cmpEnable, cmpTemp}), 32'd0);
        checkOutput("async reset result", 32'({found, matchAddr}), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        checkOutput("aborted reads consumed", 32'(addrQ.size()), 32'd0);
        pushAddrs(16); pushResult(1'b1, 4'h8, 16);
        applyStimulus(8'h9F);
        waitDone(40);
        checkHeld(1'b1, 4'h8, 8'h9F);

        checkOutput("scoreboard drained", 32'(addrQ.size() + resQ.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule : tb_lfsr_search_ctrl
